// File: rtl/conv1d_stream.sv
// Streaming 1-D linear convolution y[n] = sum h[k]*x[n-k] with programmable taps, valid/ready
// handshakes and an automatic zero-flush, so each frame of N samples yields N+TAPS-1 outputs.
module conv1d_stream #(
  parameter int unsigned  TAPS      = 4,
  parameter int unsigned  DATA_W    = 6,
  parameter int unsigned  COEF_W    = 6,
  parameter int unsigned  ACC_W     = DATA_W + COEF_W + $clog2(TAPS),
  parameter int unsigned  OUT_W     = 6,
  parameter int unsigned  OUT_SHIFT = 0,
  parameter bit           SATURATE  = 1'b1,
  localparam int unsigned IDX_W     = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              coef_we,
  input  logic [IDX_W-1:0]  coef_idx,
  input  logic [COEF_W-1:0] coef_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic              out_ovf,
  output logic              busy
);

  localparam int unsigned CNT_W     = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned IDX_CMP_W = IDX_W + 1;

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [COEF_W-1:0] coef_q [TAPS];
  logic [DATA_W-1:0] line_q [TAPS];
  logic [DATA_W-1:0] line_d [TAPS];
  logic [DATA_W-1:0] line_shift [TAPS];

  logic              out_valid_q, out_valid_d;
  logic [OUT_W-1:0]  out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              out_ovf_q, out_ovf_d;

  logic              out_free, in_fire, adv, frame_end, ovf, coef_hit;
  logic [ACC_W-1:0]  sum, scaled;
  logic [OUT_W-1:0]  narrow;

  // Out-of-range indices are dropped rather than aliased onto a real tap.
  assign coef_hit = coef_we && ({1'b0, coef_idx} < IDX_CMP_W'(TAPS));

  assign out_free = !out_valid_q || out_ready;
  assign in_ready = (state_q == StRun) && out_free;
  assign in_fire  = in_valid && in_ready;
  assign adv      = out_free && (in_fire || (state_q == StFlush));

  // Post-shift view of the line; zeros enter while flushing.
  always_comb begin
    line_shift[0] = in_fire ? in_data : '0;
    for (int k = 1; k < TAPS; k++) begin
      line_shift[k] = line_q[k-1];
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < TAPS; k++) begin
      sum = sum + ACC_W'(coef_q[k]) * ACC_W'(line_shift[k]);
    end
  end

  assign scaled = sum >> OUT_SHIFT;
  assign ovf    = (scaled >> OUT_W) != '0;
  assign narrow = (SATURATE && ovf) ? {OUT_W{1'b1}} : OUT_W'(scaled);

  // Final output of a frame: last flush step, or the last sample itself when there is no flush.
  always_comb begin
    frame_end = 1'b0;
    if (state_q == StFlush) begin
      frame_end = (cnt_q == CNT_W'(1));
    end else if (TAPS == 1) begin
      frame_end = in_fire && in_last;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_ovf_d   = out_ovf_q;
    if (adv) begin
      out_valid_d = 1'b1;
      out_data_d  = narrow;
      out_last_d  = frame_end;
      out_ovf_d   = ovf;
      line_d      = line_shift;
      if (frame_end) begin
        for (int k = 0; k < TAPS; k++) begin
          line_d[k] = '0;
        end
      end
      unique case (state_q)
        StRun: begin
          if (in_last && (TAPS > 1)) begin
            state_d = StFlush;
            cnt_d   = CNT_W'(TAPS - 1);
          end
        end
        StFlush: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (frame_end) begin
            state_d = StRun;
          end
        end
        default: state_d = StRun;
      endcase
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      out_ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StRun;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
      for (int k = 0; k < TAPS; k++) begin
        coef_q[k] <= '0;
        line_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ovf_q   <= out_ovf_d;
      line_q      <= line_d;
      if (coef_hit) begin
        coef_q[coef_idx] <= coef_data;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_ovf   = out_ovf_q;
  assign busy      = (state_q == StFlush) || out_valid_q;

endmodule

// File: tb/tb_conv1d_stream.sv
// Directed bench for conv1d_stream: saturating and wrapping 4-tap instances share stimulus,
// a 1-tap instance covers the no-flush path.
module tb_conv1d_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       coef_we;
  logic [1:0] coef_idx;
  logic [5:0] coef_data;
  logic       in_valid, in_last, out_ready;
  logic [5:0] in_data;

  logic       s_in_ready, s_out_valid, s_out_last, s_out_ovf, s_busy;
  logic [5:0] s_out_data;
  logic       w_in_ready, w_out_valid, w_out_last, w_out_ovf, w_busy;
  logic [5:0] w_out_data;

  logic       c_coef_we, c_coef_idx, c_in_valid, c_in_last, c_out_ready;
  logic [5:0] c_coef_data, c_in_data;
  logic       c_in_ready, c_out_valid, c_out_last, c_out_ovf, c_busy;
  logic [5:0] c_out_data;

  conv1d_stream #(.SATURATE(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .out_last(s_out_last), .out_ovf(s_out_ovf), .busy(s_busy)
  );

  conv1d_stream #(.SATURATE(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_idx(coef_idx), .coef_data(coef_data),
    .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data),
    .out_last(w_out_last), .out_ovf(w_out_ovf), .busy(w_busy)
  );

  conv1d_stream #(.TAPS(1)) u_t1 (
    .clk(clk), .rst_n(rst_n), .coef_we(c_coef_we), .coef_idx(c_coef_idx),
    .coef_data(c_coef_data), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_last(c_in_last), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out_data), .out_last(c_out_last),
    .out_ovf(c_out_ovf), .busy(c_busy)
  );

  int checks = 0;
  int failures = 0;

  int x_q[$];
  int ea_q[$];
  int eb_q[$];
  bit eovf;

  int bp_exp[7] = '{1, 3, 6, 10, 9, 7, 4};
  int sent, prod, cyc;
  bit mv, exp_rdy, adv_m, stalled;
  logic [5:0] held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_coef(input int idx, input int val);
    coef_we   = 1'b1;
    coef_idx  = 2'(idx);
    coef_data = 6'(val);
    step();
    coef_we   = 1'b0;
  endtask

  task automatic write_h(input int h0, input int h1, input int h2, input int h3);
    write_coef(0, h0);
    write_coef(1, h1);
    write_coef(2, h2);
    write_coef(3, h3);
  endtask

  // Streams x_q with out_ready held high; checks every output the cycle after its advance.
  task automatic run_frame(input string tag, input int steps, input bit idle);
    int n;
    int tot;
    n   = x_q.size();
    tot = ea_q.size();
    for (int i = 0; i < steps; i++) begin
      in_valid = (i < n);
      in_data  = (i < n) ? 6'(x_q[i]) : 6'd0;
      in_last  = (i == n - 1);
      #1;
      chk({tag, " in_ready"}, s_in_ready, (i < n));
      step();
      chk({tag, " valid"}, s_out_valid, 1);
      chk({tag, " sat data"}, s_out_data, ea_q[i]);
      chk({tag, " wrap data"}, w_out_data, eb_q[i]);
      chk({tag, " last"}, s_out_last, (i == tot - 1));
      chk({tag, " sat ovf"}, s_out_ovf, eovf);
      chk({tag, " wrap ovf"}, w_out_ovf, eovf);
      chk({tag, " busy"}, s_busy, 1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (idle) begin
      step();
      chk({tag, " idle valid"}, s_out_valid, 0);
      chk({tag, " idle busy"}, s_busy, 0);
      chk({tag, " idle in_ready"}, s_in_ready, 1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    coef_we = 1'b0; coef_idx = '0; coef_data = '0;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    c_coef_we = 1'b0; c_coef_idx = 1'b0; c_coef_data = '0;
    c_in_valid = 1'b0; c_in_data = '0; c_in_last = 1'b0; c_out_ready = 1'b1;
    #12;
    chk("reset valid", s_out_valid, 0);
    chk("reset data", s_out_data, 0);
    chk("reset last", s_out_last, 0);
    chk("reset ovf", s_out_ovf, 0);
    chk("reset busy", s_busy, 0);
    chk("reset in_ready", s_in_ready, 1);
    rst_n = 1'b1;

    // Basic frame, no overflow.
    write_h(1, 2, 3, 4);
    x_q = '{1, 1, 1, 1};
    ea_q = '{1, 3, 6, 10, 9, 7, 4};
    eb_q = '{1, 3, 6, 10, 9, 7, 4};
    eovf = 1'b0;
    run_frame("basic", 7, 1'b1);

    // Overflow: clamp vs wrap.
    write_h(63, 63, 63, 63);
    x_q = '{63, 63};
    ea_q = '{63, 63, 63, 63, 63};
    eb_q = '{1, 2, 2, 2, 1};
    eovf = 1'b1;
    run_frame("ovf", 5, 1'b1);

    // Single-sample frames back to back; the second must see a clean line.
    write_h(1, 2, 3, 4);
    eovf = 1'b0;
    x_q = '{5};
    ea_q = '{5, 10, 15, 20};
    eb_q = '{5, 10, 15, 20};
    run_frame("single", 4, 1'b0);
    x_q = '{2};
    ea_q = '{2, 4, 6, 8};
    eb_q = '{2, 4, 6, 8};
    run_frame("next", 4, 1'b1);

    // Backpressure with out_ready toggling every cycle.
    sent = 0; prod = 0; cyc = 0; mv = 1'b0;
    while (!(prod == 7 && !mv) && cyc < 40) begin
      out_ready = (cyc % 2 == 0);
      in_valid  = (sent < 4);
      in_data   = 6'd1;
      in_last   = (sent == 3);
      #1;
      exp_rdy = (!mv || out_ready) && !(sent == 4 && prod < 7);
      chk("bp in_ready", s_in_ready, exp_rdy);
      adv_m   = (!mv || out_ready) && (prod < 7);
      stalled = mv && !out_ready;
      held    = s_out_data;
      step();
      if (adv_m) begin
        if (sent < 4) sent++;
        prod++;
        mv = 1'b1;
      end else if (mv && out_ready) begin
        mv = 1'b0;
      end
      chk("bp valid", s_out_valid, mv);
      if (mv) begin
        chk("bp data", s_out_data, bp_exp[prod-1]);
        chk("bp wrap data", w_out_data, bp_exp[prod-1]);
        chk("bp last", s_out_last, (prod == 7));
      end
      if (stalled) chk("bp hold", s_out_data, held);
      cyc++;
    end
    chk("bp outputs", prod, 7);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;

    // Reset during flush, then verify coefficients were cleared.
    x_q = '{1, 1, 1, 1};
    ea_q = '{1, 3, 6, 10, 9, 7, 4};
    eb_q = '{1, 3, 6, 10, 9, 7, 4};
    run_frame("prerst", 5, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst valid", s_out_valid, 0);
    chk("rst data", s_out_data, 0);
    chk("rst last", s_out_last, 0);
    chk("rst busy", s_busy, 0);
    chk("rst in_ready", s_in_ready, 1);
    #2;
    rst_n = 1'b1;
    step();
    x_q = '{1};
    ea_q = '{0, 0, 0, 0};
    eb_q = '{0, 0, 0, 0};
    run_frame("zcoef", 4, 1'b1);
    write_h(1, 2, 3, 4);
    ea_q = '{1, 2, 3, 4};
    eb_q = '{1, 2, 3, 4};
    run_frame("postrst", 4, 1'b1);

    // Single tap: no flush, out-of-range coefficient write dropped.
    c_coef_we = 1'b1; c_coef_idx = 1'b0; c_coef_data = 6'd3;
    step();
    c_coef_idx = 1'b1; c_coef_data = 6'd7;
    step();
    c_coef_we = 1'b0;
    c_in_valid = 1'b1; c_in_data = 6'd4; c_in_last = 1'b0;
    #1;
    chk("t1 in_ready0", c_in_ready, 1);
    step();
    chk("t1 data0", c_out_data, 12);
    chk("t1 last0", c_out_last, 0);
    c_in_data = 6'd5; c_in_last = 1'b1;
    #1;
    chk("t1 in_ready1", c_in_ready, 1);
    step();
    chk("t1 data1", c_out_data, 15);
    chk("t1 last1", c_out_last, 1);
    chk("t1 ovf1", c_out_ovf, 0);
    c_in_data = 6'd2; c_in_last = 1'b1;
    #1;
    chk("t1 in_ready2", c_in_ready, 1);
    step();
    chk("t1 data2", c_out_data, 6);
    chk("t1 last2", c_out_last, 1);
    c_in_valid = 1'b0; c_in_last = 1'b0;
    step();
    chk("t1 idle valid", c_out_valid, 0);
    chk("t1 idle busy", c_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
